multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM plus ALU/immediate decoders for the multicycle RV32 core.
//  Drives ResultSrc (00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt) and every other datapath select/enable, one state per cycle.
//  Sits beside the datapath; consumes IR fields and ALU Zero.
// PARAMETERS
//  ILLEGAL_HALT  0  1: unknown opcode -> HALT (sticky until reset); 0: unknown opcode -> FETCH (treated as NOP)
// PORTS
//  clk          in   1  clock, all state updates on posedge
//  reset        in   1  synchronous, active-high; forces state FETCH
//  op           in   7  Instr[6:0] from IR
//  funct3       in   3  Instr[14:12]
//  funct7b5     in   1  Instr[30]
//  Zero         in   1  ALU result == 0
//  PCWrite      out  1  PC enable = PCUpdate | (Branch & taken)
//  AdrSrc       out  1  memory address: 0 PC, 1 ALUOut
//  MemWrite     out  1  data memory write enable
//  IRWrite      out  1  IR/OldPC load enable
//  RegWrite     out  1  register file write enable
//  ResultSrc    out  2  result mux select (encoding above)
//  ALUSrcA      out  2  00 PC, 01 OldPC, 10 RD1 (A reg)
//  ALUSrcB      out  2  00 RD2 (WriteData reg), 01 ImmExt, 10 constant 4
//  ALUControl   out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  ImmSrc       out  3  000 I, 001 S, 010 B, 011 J, 100 U
//  halted       out  1  1 while in HALT
//  state_o      out  4  current state encoding (debug/verification)
// BEHAVIOUR
//  - Moore outputs decoded from state; ImmSrc/ALUControl also from op/funct fields. Unlisted outputs = 0.
//  - Reset: state <= FETCH on next edge; while reset high, PCWrite/MemWrite/IRWrite/RegWrite forced 0, others as FETCH.
//  - FETCH: AdrSrc0 IRWrite ALUSrcA00 ALUSrcB10 add ResultSrc10 PCUpdate -> DECODE.
//  - DECODE: ALUSrcA01 ALUSrcB01 add (branch/jump target into ALUOut). Next by op:
//    0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH,
//    1101111->JAL, 0110111->LUI, else HALT (ILLEGAL_HALT=1) or FETCH.
//  - MEMADR: ALUSrcA10 ALUSrcB01 add; op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
//  - MEMREAD: ResultSrc00 AdrSrc1 -> MEMWB.  MEMWB: ResultSrc01 RegWrite -> FETCH.
//  - MEMWRITE: ResultSrc00 AdrSrc1 MemWrite -> FETCH.
//  - EXECR: ALUSrcA10 ALUSrcB00 ALUOp=funct -> ALUWB.  EXECI: ALUSrcA10 ALUSrcB01 ALUOp=funct -> ALUWB.
//  - ALUWB: ResultSrc00 RegWrite -> FETCH.
//  - JAL: ALUSrcA01 ALUSrcB10 add ResultSrc00 PCUpdate (PC<=target, ALUOut<=PC+4) -> ALUWB.
//  - BRANCH: ALUSrcA10 ALUSrcB00 sub ResultSrc00 Branch; taken = Zero ^ funct3[0] (beq/bne); -> FETCH.
//  - LUI: ResultSrc11 RegWrite -> FETCH.  HALT: all enables 0, halted=1, stays until reset.
//  - ALU decode: ALUOp add/sub fixed per state; funct mode: funct3 000 -> sub iff op[5]&funct7b5 else add;
//    010 slt; 110 or; 111 and; other funct3 -> add.
//  - ImmSrc by op: I-type/lw/jalr-class 000, sw 001, branch 010, jal 011, lui 100, else 000.
//  - CPI: lw 5, sw 4, R/I 4, jal 4, branch 3, lui 3. Exactly one of MemWrite/RegWrite/IRWrite per cycle max.
//  - Reset mid-instruction: abandons instruction, no write enable asserted in reset cycle or after it.
// TESTING
//  lw (op 0000011): reset, step -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; RegWrite=1 only in MEMWB with ResultSrc=01.
//  add/sub R-type funct7b5=1 funct3=000 -> EXECR ALUControl=001, ALUWB RegWrite=1 ResultSrc=00, 4 cycles.
//  beq with Zero=1 -> BRANCH PCWrite=1 ALUControl=001; Zero=0 -> PCWrite=0; bne (funct3=001) inverts both.
//  lui op 0110111 -> LUI ResultSrc=11 RegWrite=1 ImmSrc=100, back to FETCH in 3 cycles.
//  op 1111111, ILLEGAL_HALT=1 -> HALT, halted=1, all enables 0 for 20 cycles; reset -> FETCH.
//  reset asserted in MEMWRITE cycle -> MemWrite=0 that cycle, FETCH next edge, IRWrite=1 after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM plus ALU and immediate decoders for a
// multicycle RV32 core. Sits beside the datapath and consumes the IR fields and ALU Zero.
// The controls are Moore outputs decoded from the current state. ImmSrc and ALUControl
// also depend on the IR fields.
// Ports:
//   clk, reset        clock and synchronous active-high reset (state -> FETCH)
//   op/funct3/funct7b5 instruction fields from the IR; Zero from the ALU
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc  datapath selects and enables
//   halted            high while in HALT; state_o exposes the state register
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       halted,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_dec_state;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic [1:0] w_alu_op;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_LUI:            w_next = S_LUI;
          default:           w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  // While reset is high, the selects decode as FETCH. The enables are masked below.
  assign w_dec_state = reset ? S_FETCH : r_state;

  // Moore control decode
  always_comb begin
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    halted      = 1'b0;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_irwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    w_alu_op    = ALUOP_ADD;
    case (w_dec_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA  = 2'b10;
        w_alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = ALUOP_FUNCT;
      end
      S_ALUWB:    w_regwrite = 1'b1;
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 2'b10;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
      end
      S_LUI: begin
        ResultSrc  = 2'b11;
        w_regwrite = 1'b1;
      end
      S_HALT:     halted = 1'b1;
      default:    ;
    endcase
  end

  // funct3[0] separates bne from beq, so it inverts the Zero test.
  assign PCWrite  = ~reset & (w_pc_update | (w_branch & (Zero ^ funct3[0])));
  assign IRWrite  = ~reset & w_irwrite;
  assign MemWrite = ~reset & w_memwrite;
  assign RegWrite = ~reset & w_regwrite;
  assign state_o  = r_state;

  // ALU decoder
  always_comb begin
    ALUControl = 3'b000;
    case (w_alu_op)
      ALUOP_SUB:   ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default:     ALUControl = 3'b000;
    endcase
  end

  // Immediate format decoder
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = 3'b000;
      OP_STORE:                   ImmSrc = 3'b001;
      OP_BRANCH:                  ImmSrc = 3'b010;
      OP_JAL:                     ImmSrc = 3'b011;
      OP_LUI:                     ImmSrc = 3'b100;
      default:                    ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. Instance a halts on illegal opcodes.
// Instance b treats them as NOPs.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [2:0] imm;
    logic       halted;
  } ctrl_t;

  typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MWR, P_ER, P_EI, P_AW, P_J, P_B, P_L, P_H} ph_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    int         cpi;
    logic [2:0] alu2;
    logic       pcw2;
    logic [2:0] imm;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, zero;

  logic a_pcw, a_adr, a_memw, a_irw, a_regw, a_halted;
  logic [1:0] a_res, a_sa, a_sb;
  logic [2:0] a_alu, a_imm;
  logic [3:0] a_state;
  logic b_pcw, b_adr, b_memw, b_irw, b_regw, b_halted;
  logic [1:0] b_res, b_sa, b_sb;
  logic [2:0] b_alu, b_imm;
  logic [3:0] b_state;

  ctrl_t act_a, act_b;
  assign act_a = {a_pcw, a_adr, a_memw, a_irw, a_regw, a_res, a_sa, a_sb, a_alu, a_imm, a_halted};
  assign act_b = {b_pcw, b_adr, b_memw, b_irw, b_regw, b_res, b_sa, b_sb, b_alu, b_imm, b_halted};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
    .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_memw), .IRWrite(a_irw), .RegWrite(a_regw),
    .ResultSrc(a_res), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUControl(a_alu), .ImmSrc(a_imm),
    .halted(a_halted), .state_o(a_state)
  );

  multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
    .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_memw), .IRWrite(b_irw), .RegWrite(b_regw),
    .ResultSrc(b_res), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUControl(b_alu), .ImmSrc(b_imm),
    .halted(b_halted), .state_o(b_state)
  );

  // Reference model: instruction class -> cycle sequence -> control word.
  function automatic int seq_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011, 7'b0110111: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic ph_t seq_at(input logic [6:0] o, input int k);
    if (k == 0) return P_F;
    if (k == 1) return P_D;
    case (o)
      7'b0000011: return (k == 2) ? P_MA : (k == 3) ? P_MR : P_MWB;
      7'b0100011: return (k == 2) ? P_MA : P_MWR;
      7'b0110011: return (k == 2) ? P_ER : P_AW;
      7'b0010011: return (k == 2) ? P_EI : P_AW;
      7'b1101111: return (k == 2) ? P_J : P_AW;
      7'b1100011: return P_B;
      7'b0110111: return P_L;
      default:    return P_H;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ctrl_t ctrl_of(input ph_t ph, input logic [6:0] o, input logic [2:0] f3,
                                    input logic f7, input logic z, input logic in_reset);
    ctrl_t c;
    c = '0;
    c.imm = imm_of(o);
    case (ph)
      P_F:   begin c.irw = 1'b1; c.sb = 2'd2; c.res = 2'd2; c.pcw = 1'b1; end
      P_D:   begin c.sa = 2'd1; c.sb = 2'd1; end
      P_MA:  begin c.sa = 2'd2; c.sb = 2'd1; end
      P_MR:  c.adr = 1'b1;
      P_MWB: begin c.res = 2'd1; c.regw = 1'b1; end
      P_MWR: begin c.adr = 1'b1; c.memw = 1'b1; end
      P_ER:  begin c.sa = 2'd2; c.alu = funct_alu(o, f3, f7); end
      P_EI:  begin c.sa = 2'd2; c.sb = 2'd1; c.alu = funct_alu(o, f3, f7); end
      P_AW:  c.regw = 1'b1;
      P_J:   begin c.sa = 2'd1; c.sb = 2'd2; c.pcw = 1'b1; end
      P_B:   begin c.sa = 2'd2; c.alu = 3'b001; c.pcw = z ^ f3[0]; end
      P_L:   begin c.res = 2'd3; c.regw = 1'b1; end
      P_H:   c.halted = 1'b1;
      default: ;
    endcase
    if (in_reset) begin
      c.pcw = 1'b0; c.irw = 1'b0; c.memw = 1'b0; c.regw = 1'b0;
    end
    return c;
  endfunction

  task automatic chk(input string name, input ctrl_t act, input ctrl_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (op=%b f3=%b f7=%b z=%b)", name, act, exp, op, funct3, funct7b5, zero);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (op=%b f3=%b)", name, act, exp, op, funct3);
    end
  endtask

  // Entered at a negedge with both DUTs in FETCH. Returns at the negedge of the next FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    ctrl_t e;
    int wr;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    for (int k = 0; k < seq_len(o); k++) begin
      #1;
      e = ctrl_of(seq_at(o, k), o, f3, f7, z, 1'b0);
      chk("seq_a", act_a, e);
      chk("seq_b", act_b, e);
      wr = int'(a_memw) + int'(a_regw) + int'(a_irw);
      if (wr > 1) begin
        n_fail++;
        $display("FAIL one_write: %0d write enables asserted together", wr);
      end
      @(negedge clk);
    end
  endtask

  vec_t tbl[15];
  logic [6:0] legal[7];
  int cpi;
  logic [2:0] alu2, imm2;
  logic pcw2;

  initial begin
    tbl[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b000, 1'b0, 3'b000};
    tbl[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 3'b000, 1'b0, 3'b001};
    tbl[2]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b001, 1'b0, 3'b000};
    tbl[3]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b0, 3'b000};
    tbl[4]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000, 1'b0, 3'b000};
    tbl[5]  = '{7'b0010011, 3'b010, 1'b0, 1'b0, 4, 3'b101, 1'b0, 3'b000};
    tbl[6]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 3'b011, 1'b0, 3'b000};
    tbl[7]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4, 3'b010, 1'b0, 3'b000};
    tbl[8]  = '{7'b0110011, 3'b100, 1'b1, 1'b0, 4, 3'b000, 1'b0, 3'b000};
    tbl[9]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b001, 1'b1, 3'b010};
    tbl[10] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b001, 1'b0, 3'b010};
    tbl[11] = '{7'b1100011, 3'b001, 1'b0, 1'b1, 3, 3'b001, 1'b0, 3'b010};
    tbl[12] = '{7'b1100011, 3'b001, 1'b0, 1'b0, 3, 3'b001, 1'b1, 3'b010};
    tbl[13] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b1, 3'b011};
    tbl[14] = '{7'b0110111, 3'b000, 1'b0, 1'b0, 3, 3'b000, 1'b0, 3'b100};
    legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0110111};

    // Reset
    reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset_a", act_a, ctrl_of(P_F, op, funct3, funct7b5, zero, 1'b1));
    chk("reset_b", act_b, ctrl_of(P_F, op, funct3, funct7b5, zero, 1'b1));
    @(negedge clk);
    reset = 1'b0;

    // Table vectors: measure CPI and probe the third cycle
    for (int i = 0; i < 15; i++) begin
      op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7; zero = tbl[i].zero;
      cpi = 0; alu2 = 3'bxxx; pcw2 = 1'bx; imm2 = 3'bxxx;
      for (int k = 0; k < 10; k++) begin
        #1;
        if (k > 0 && a_irw) begin
          cpi = k;
          break;
        end
        if (k == 2) begin
          alu2 = a_alu; pcw2 = a_pcw; imm2 = a_imm;
        end
        @(negedge clk);
      end
      chk_int("tbl_cpi", cpi, tbl[i].cpi);
      chk_int("tbl_alu", int'(alu2), int'(tbl[i].alu2));
      chk_int("tbl_pcw", int'(pcw2), int'(tbl[i].pcw2));
      chk_int("tbl_imm", int'(imm2), int'(tbl[i].imm));
      // Finish the cycle that detected the next FETCH, then re-enter it aligned.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end

    // Randomized instructions against the model
    for (int n = 0; n < 150; n++) begin
      run_instr(legal[$urandom_range(0, 6)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Illegal opcode: a halts, b treats it as a NOP
    op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    #1;
    chk("ill_f_a", act_a, ctrl_of(P_F, op, funct3, funct7b5, zero, 1'b0));
    chk("ill_f_b", act_b, ctrl_of(P_F, op, funct3, funct7b5, zero, 1'b0));
    @(negedge clk); #1;
    chk("ill_d_a", act_a, ctrl_of(P_D, op, funct3, funct7b5, zero, 1'b0));
    chk("ill_d_b", act_b, ctrl_of(P_D, op, funct3, funct7b5, zero, 1'b0));
    @(negedge clk); #1;
    chk("ill_nop_b", act_b, ctrl_of(P_F, op, funct3, funct7b5, zero, 1'b0));
    for (int k = 0; k < 20; k++) begin
      chk("halt_a", act_a, ctrl_of(P_H, op, funct3, funct7b5, zero, 1'b0));
      @(negedge clk);
      op = (k % 2 == 0) ? 7'b0000011 : 7'b1111111;
      #1;
    end
    reset = 1'b1;
    #1;
    chk("halt_rst_a", act_a, ctrl_of(P_F, op, funct3, funct7b5, zero, 1'b1));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("halt_exit_a", act_a, ctrl_of(P_F, op, funct3, funct7b5, zero, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset during the MEMWRITE cycle of a store
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("sw_pre", act_a, ctrl_of(seq_at(op, k), op, funct3, funct7b5, zero, 1'b0));
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk("sw_rst_a", act_a, ctrl_of(P_F, op, funct3, funct7b5, zero, 1'b1));
    chk("sw_rst_b", act_b, ctrl_of(P_F, op, funct3, funct7b5, zero, 1'b1));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("sw_after_a", act_a, ctrl_of(P_F, op, funct3, funct7b5, zero, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // A few more instructions after the reset to confirm a clean restart
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    run_instr(7'b0110111, 3'b000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
